// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: banked single-port RAM controller with valid/ready requests,
// selectable write response modes and a zero-fill sequencer.
module sp_ram_ctrl #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 15,
  parameter int BANK_W         = 1,
  parameter int OUT_REG        = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              busy
);
  localparam int BANKS = 1 << BANK_W;
  localparam int IDX_W = ADDR_W - BANK_W;
  localparam int SEL_W = (BANK_W > 0) ? BANK_W : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  logic [0:0]        state;
  logic [ADDR_W:0]   clr_addr;
  logic              clearing, acc, m_we, m_re, rsp_gen;
  logic [ADDR_W-1:0] m_addr;
  logic [SEL_W-1:0]  m_sel, p1_sel;
  logic [IDX_W-1:0]  m_idx;
  logic [DATA_W-1:0] m_wd, p1_wd, hold, bq, d1;
  logic              p1_v, p1_wt, r_v;
  logic [DATA_W-1:0] bank_q [BANKS];
  assign clearing  = state == CLEAR;
  assign busy      = clearing;
  assign req_ready = (state == IDLE) && !clr_start;
  assign acc       = req_valid && req_ready;
  assign m_addr    = clearing ? clr_addr[ADDR_W-1:0] : req_addr;
  assign m_idx     = m_addr[IDX_W-1:0];
  assign m_we      = clearing || (acc && req_we);
  assign m_wd      = clearing ? '0 : req_wdata;
  assign m_re      = acc && (!req_we || WRITE_MODE == 2);
  assign rsp_gen   = acc && (!req_we || WRITE_MODE != 0);
  if (BANK_W > 0) begin : g_sel
    assign m_sel = m_addr[ADDR_W-1 -: BANK_W];
    assign bq    = bank_q[p1_sel];
  end else begin : g_nosel
    assign m_sel = '0;
    assign bq    = bank_q[0];
  end
  // Read port only advances on an accepted request so the output mux holds steady.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [2**IDX_W];
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk) begin
      if (m_we && m_sel == SEL_W'(b)) mem[m_idx] <= m_wd;
      if (m_re && m_sel == SEL_W'(b)) q <= mem[m_idx];
    end
    assign bank_q[b] = q;
  end
  assign d1        = p1_wt ? p1_wd : bq;
  assign rsp_valid = (OUT_REG != 0) ? r_v : p1_v;
  assign rsp_rdata = (OUT_REG == 0 && p1_v) ? d1 : hold;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr <= '0;
      p1_v     <= 1'b0;
      p1_wt    <= 1'b0;
      p1_sel   <= '0;
      p1_wd    <= '0;
      hold     <= '0;
      r_v      <= 1'b0;
    end else begin
      if (clearing) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == (ADDR_W+1)'((1 << ADDR_W) - 1)) state <= IDLE;
      end else if (clr_start) begin
        state    <= CLEAR;
        clr_addr <= '0;
      end
      p1_v <= rsp_gen;
      if (acc) begin
        p1_sel <= m_sel;
        p1_wt  <= req_we && WRITE_MODE == 1;
        p1_wd  <= req_wdata;
      end
      if (p1_v) hold <= d1;
      r_v <= p1_v;
    end
  end
endmodule
